sram_init_bridge: RTL and testbench
===================================

# sram_init_bridge

On-chip memory stage directly downstream of the SLC-3 top level: it consumes the CPU's `ADDR`, `Data_to_SRAM`, `OE` and `WE` and produces `Data_from_SRAM`, standing in for the physical SRAM. After reset it copies a program image from an external init ROM into its storage and reports readiness. It then serves single-word CPU reads with one cycle of latency and synchronous CPU writes.

## Interface
- `DEPTH_W`, default 10: storage is 2^DEPTH_W 16-bit words.
- `INIT_WORDS`, default 256: number of words copied from ROM. Legal range 1..2^DEPTH_W.
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high.
- `Reload`  in  1  synchronous single-cycle pulse; restarts the ROM copy.
- `ADDR`  in  16  CPU word address (driven from MAR).
- `Data_to_SRAM`  in  16  CPU write data.
- `OE`  in  1  read enable, active-low.
- `WE`  in  1  write enable, active-low.
- `Data_from_SRAM`  out  16  registered read data.
- `rom_addr`  out  DEPTH_W  init-ROM address; combinational from the load counter.
- `rom_data`  in  16  init-ROM data; the ROM is synchronous with 1-cycle latency.
- `mem_ready`  out  1  high when CPU accesses are serviced.

## Operation
- **States**
  - LOAD: entered on Reset or on Reload.
  - READY: normal CPU service.
- **LOAD, on each edge**
  - Write pipeline: if `wr_valid_q`, then `mem[wr_addr_q] <= rom_data`.
  - Address capture: `wr_addr_q <= cnt` and `wr_valid_q <= (cnt < INIT_WORDS)`.
  - Counter: `cnt <= cnt + 1`.
  - Exit: when `cnt == INIT_WORDS` and `wr_valid_q` is low, go to READY and clear `cnt`.
- **ROM address:** `rom_addr = cnt[DEPTH_W-1:0]`.
- **CPU access during LOAD:** CPU writes are ignored and `Data_from_SRAM` is held at 0x0000.
- **READY, range check:** an access is in range when `ADDR[15:DEPTH_W] == 0`.
- **READY, write:** when `WE == 0` and the address is in range, `mem[ADDR[DEPTH_W-1:0]] <= Data_to_SRAM`. This is repeated every cycle that WE is held low, which is idempotent.
- **READY, read:** when `OE == 0` and `WE == 1`, `Data_from_SRAM <= mem[ADDR]` if in range, else 0x0000.
- **READY, idle:** when `OE == 1` and `WE == 1`, `Data_from_SRAM` holds its value.
- **OE and WE both low:** the write is performed and `Data_from_SRAM` holds its previous value.
- **Read-after-write to the same address on the next cycle:** returns the new data.
- **Reload in READY:** go to LOAD with `cnt = 0` and `wr_valid_q = 0`. A simultaneous CPU write is dropped. `Data_from_SRAM` is cleared to 0x0000 on the next edge.
- **Reload during LOAD:** restarts the copy from word 0.
- **Words at or above INIT_WORDS:** not touched by LOAD; they keep prior contents, which are undefined after power-up.

## Timing
- **Reset values:** state LOAD, `cnt = 0`, `wr_valid_q = 0`, `Data_from_SRAM = 0x0000`, `mem_ready = 0`, `rom_addr = 0`.
- **Load duration:** with edge 1 being the first rising edge after Reset falls, ROM word i is written at edge i+2. READY is entered at edge INIT_WORDS+2, and `mem_ready` is high from then on.
- **`mem_ready`:** registered; it equals (state == READY).
- **Read latency:** `ADDR` and `OE` are sampled at edge n, and data is valid after edge n, in time for MDR capture at edge n+1.
- **Write:** takes effect at the sampling edge; there is no write latency.
- **Reset mid-LOAD or mid-access:** takes immediate asynchronous effect. The copy restarts from word 0 after release.
- **Memory array:** not cleared by Reset.

## Test plan
- **Initial load:** ROM model holds word[i] = 0x3000+i, INIT_WORDS=256; release Reset -> `mem_ready` low through edge 257 and high after edge 258. Reading addresses 0x0000, 0x0055 and 0x00FF returns 0x3000, 0x3055 and 0x30FF, each one cycle after OE falls.
- **Write then read:** in READY, WE=0 with ADDR=0x0010 and data 0xBEEF for one cycle, then OE=0 with ADDR=0x0010 -> `Data_from_SRAM` = 0xBEEF after the next edge. Address 0x0011 is unchanged.
- **Out of range:** DEPTH_W=10; write 0x1234 to ADDR=0x0400 -> a read of 0x0400 returns 0x0000, and a read of 0x0000 still returns 0x3000.
- **Simultaneous OE/WE:** OE=0 and WE=0 at 0x0020 with data 0xAAAA -> `Data_from_SRAM` holds its previous value that cycle. A following read of 0x0020 returns 0xAAAA.
- **Reload:** pulse Reload together with WE=0 at 0x0005 and data 0x1111 -> the write is dropped, `mem_ready` falls at the next edge and rises 258 edges later. Address 0x0005 reads 0x3005.
- **Reset mid-load:** assert Reset at edge 100 of LOAD, release it, and change the ROM image to word[i] = 0x5000+i -> after the full 258-edge load, address 0x0000 reads 0x5000 and address 0x00FF reads 0x50FF.

Source files
------------

// File: rtl/sram_init_bridge.sv
// sram_init_bridge
//   On-chip SRAM stand-in for the SLC-3 CPU. After Reset (or a Reload pulse)
//   it copies INIT_WORDS words from a synchronous init ROM into its storage.
//   It then serves CPU reads with one cycle of latency and CPU writes
//   synchronously.
//
// Ports
//   Clk, Reset     : system clock, asynchronous active-high reset
//   Reload         : single-cycle pulse, restarts the ROM copy
//   ADDR           : CPU word address (from MAR)
//   Data_to_SRAM   : CPU write data
//   OE, WE         : active-low read / write enables
//   Data_from_SRAM : registered read data
//   rom_addr       : init-ROM address, combinational from the load counter
//   rom_data       : init-ROM data, one cycle after rom_addr
//   mem_ready      : high while CPU accesses are serviced
module sram_init_bridge #(
  parameter int unsigned DEPTH_W    = 10,
  parameter int unsigned INIT_WORDS = 256
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Reload,
  input  logic [15:0]        ADDR,
  input  logic [15:0]        Data_to_SRAM,
  input  logic               OE,
  input  logic               WE,
  output logic [15:0]        Data_from_SRAM,
  output logic [DEPTH_W-1:0] rom_addr,
  input  logic [15:0]        rom_data,
  output logic               mem_ready
);

  localparam int unsigned Words = 2 ** DEPTH_W;

  // One extra bit so the counter can hold INIT_WORDS == 2^DEPTH_W.
  localparam logic [DEPTH_W:0] CntLast = (DEPTH_W + 1)'(INIT_WORDS);

  localparam logic [0:0] StLoad  = 1'b0;
  localparam logic [0:0] StReady = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [DEPTH_W:0]   cnt_q, cnt_d;
  logic               wr_valid_q, wr_valid_d;
  logic [DEPTH_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]        rdata_q, rdata_d;

  logic [15:0]        mem [Words];

  logic               mem_we;
  logic [DEPTH_W-1:0] mem_waddr;
  logic [15:0]        mem_wdata;

  logic [DEPTH_W-1:0] cpu_idx;
  logic               in_range;

  assign cpu_idx  = ADDR[DEPTH_W-1:0];
  assign in_range = ((ADDR >> DEPTH_W) == 16'h0000);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr_q;
    mem_wdata  = rom_data;

    if (Reload) begin
      // Restart the copy; any CPU write or in-flight ROM write this cycle is dropped.
      state_d    = StLoad;
      cnt_d      = '0;
      wr_valid_d = 1'b0;
      rdata_d    = 16'h0000;
    end else begin
      case (state_q)
        StLoad: begin
          rdata_d = 16'h0000;
          // ROM data arrives one cycle after its address, so the write trails
          // the counter by one stage.
          mem_we     = wr_valid_q;
          wr_addr_d  = cnt_q[DEPTH_W-1:0];
          wr_valid_d = (cnt_q < CntLast);
          if (cnt_q < CntLast) begin
            cnt_d = cnt_q + 1'b1;
          end
          // Leave only once the last ROM word has drained into memory.
          if ((cnt_q == CntLast) && !wr_valid_q) begin
            state_d = StReady;
            cnt_d   = '0;
          end
        end
        StReady: begin
          if (!WE && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = cpu_idx;
            mem_wdata = Data_to_SRAM;
          end
          // With OE and WE both low the write wins and read data holds.
          if (!OE && WE) begin
            rdata_d = in_range ? mem[cpu_idx] : 16'h0000;
          end
        end
        default: state_d = StLoad;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= StLoad;
      cnt_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      rdata_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage is deliberately not reset; contents survive Reset.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign Data_from_SRAM = rdata_q;
  assign rom_addr       = cnt_q[DEPTH_W-1:0];
  assign mem_ready      = (state_q == StReady);

endmodule

// File: tb/tb_sram_init_bridge.sv
// tb_sram_init_bridge
//   Directed bench for sram_init_bridge with DEPTH_W=10, INIT_WORDS=256.
//   The init ROM is modelled as a registered lookup returning rom_base + address.
module tb_sram_init_bridge;

  localparam int unsigned DepthW    = 10;
  localparam int unsigned InitWords = 256;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Reload;
  logic [15:0]       ADDR;
  logic [15:0]       Data_to_SRAM;
  logic              OE;
  logic              WE;
  logic [15:0]       Data_from_SRAM;
  logic [DepthW-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              mem_ready;

  logic [15:0]       rom_base;
  int                n_checks = 0;
  int                n_errors = 0;

  sram_init_bridge #(
    .DEPTH_W   (DepthW),
    .INIT_WORDS(InitWords)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Reload        (Reload),
    .ADDR          (ADDR),
    .Data_to_SRAM  (Data_to_SRAM),
    .OE            (OE),
    .WE            (WE),
    .Data_from_SRAM(Data_from_SRAM),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .mem_ready     (mem_ready)
  );

  always #5 Clk = ~Clk;

  // Synchronous init ROM, one cycle of latency.
  always @(posedge Clk) rom_data <= rom_base + 16'(rom_addr);

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic cpu_read(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    ADDR = addr;
    OE   = 1'b0;
    WE   = 1'b1;
    step();
    check(tag, Data_from_SRAM, exp);
    OE = 1'b1;
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [15:0] data);
    ADDR         = addr;
    Data_to_SRAM = data;
    WE           = 1'b0;
    step();
    WE = 1'b1;
  endtask

  // Counts edges from the start of a load; READY must appear exactly at edge 258.
  // With poke set, the CPU tries to write and read during edges 10..15.
  task automatic wait_load(input string tag, input bit poke);
    for (int e = 1; e <= InitWords + 2; e++) begin
      if (poke && e == 10) begin
        ADDR         = 16'h03FF;
        Data_to_SRAM = 16'h9999;
        WE           = 1'b0;
        OE           = 1'b0;
      end
      step();
      if (e == 1) check({tag, "_rom_addr_e1"}, 16'(rom_addr), 16'h0001);
      if (poke && e == 15) begin
        check({tag, "_rdata_in_load"}, Data_from_SRAM, 16'h0000);
        WE = 1'b1;
        OE = 1'b1;
      end
      if (e == InitWords + 1) check({tag, "_ready_e257"}, 16'(mem_ready), 16'h0000);
      if (e == InitWords + 2) check({tag, "_ready_e258"}, 16'(mem_ready), 16'h0001);
    end
  endtask

  initial begin
    Reset        = 1'b1;
    Reload       = 1'b0;
    ADDR         = 16'h0000;
    Data_to_SRAM = 16'h0000;
    OE           = 1'b1;
    WE           = 1'b1;
    rom_base     = 16'h3000;

    // Reset state
    #1;
    check("rst_ready", 16'(mem_ready), 16'h0000);
    check("rst_rdata", Data_from_SRAM, 16'h0000);
    check("rst_rom_addr", 16'(rom_addr), 16'h0000);
    step();
    step();
    @(negedge Clk);
    Reset = 1'b0;

    // Initial load
    wait_load("load1", 1'b0);
    cpu_read(16'h0000, 16'h3000, "rd_0000");
    cpu_read(16'h0055, 16'h3055, "rd_0055");
    cpu_read(16'h00FF, 16'h30FF, "rd_00ff");

    // Write then read, neighbour untouched
    cpu_write(16'h0010, 16'hBEEF);
    cpu_read(16'h0010, 16'hBEEF, "raw_0010");
    cpu_read(16'h0011, 16'h3011, "rd_0011");

    // Out of range
    cpu_write(16'h0400, 16'h1234);
    cpu_read(16'h0400, 16'h0000, "oor_0400");
    cpu_read(16'h0000, 16'h3000, "oor_alias_0000");

    // OE and WE both low: write happens, read data holds
    ADDR         = 16'h0020;
    Data_to_SRAM = 16'hAAAA;
    OE           = 1'b0;
    WE           = 1'b0;
    step();
    check("both_low_hold", Data_from_SRAM, 16'h3000);
    OE = 1'b1;
    WE = 1'b1;
    cpu_read(16'h0020, 16'hAAAA, "both_low_wr");

    // Idle holds read data
    ADDR = 16'h0010;
    step();
    check("idle_hold", Data_from_SRAM, 16'hAAAA);

    // Top in-range word, above the init region
    cpu_write(16'h03FF, 16'h7777);
    cpu_read(16'h03FF, 16'h7777, "rd_03ff");

    // Reload with a simultaneous write that must be dropped
    ADDR         = 16'h0005;
    Data_to_SRAM = 16'h1111;
    WE           = 1'b0;
    Reload       = 1'b1;
    step();
    Reload = 1'b0;
    WE     = 1'b1;
    check("reload_ready", 16'(mem_ready), 16'h0000);
    check("reload_rdata", Data_from_SRAM, 16'h0000);
    wait_load("load2", 1'b1);
    cpu_read(16'h0005, 16'h3005, "reload_0005");
    cpu_read(16'h0010, 16'h3010, "reload_0010");
    cpu_read(16'h03FF, 16'h7777, "load_wr_ignored");

    // Asynchronous reset from READY, then again mid-load with a new ROM image
    #2;
    Reset = 1'b1;
    #1;
    check("async_rst_rdata", Data_from_SRAM, 16'h0000);
    check("async_rst_ready", 16'(mem_ready), 16'h0000);
    @(negedge Clk);
    Reset = 1'b0;
    for (int e = 1; e <= 100; e++) step();
    Reset = 1'b1;
    #1;
    check("midload_rom_addr", 16'(rom_addr), 16'h0000);
    rom_base = 16'h5000;
    @(negedge Clk);
    Reset = 1'b0;
    wait_load("load3", 1'b0);
    cpu_read(16'h0000, 16'h5000, "rst_rd_0000");
    cpu_read(16'h0080, 16'h5080, "rst_rd_0080");
    cpu_read(16'h00FF, 16'h50FF, "rst_rd_00ff");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
